// File: rtl/row_memory_streamer_if.sv
// rtl/row_memory_streamer_if.sv - request/acknowledge bus between the row streamer and the row store
interface row_memory_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  memReq;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWData;
    logic [DATA_WIDTH-1:0] memRData;
    logic                  memAck;

    modport master (output memReq, memWe, memAddr, memWData, input memRData, memAck);
    modport slave  (input memReq, memWe, memAddr, memWData, output memRData, memAck);
endinterface

// File: rtl/row_memory_streamer.sv
// rtl/row_memory_streamer.sv - per-line write-back of the next generation and fetch of the next source row
module row_memory_streamer #(
    parameter int DATA_WIDTH     = 16,
    parameter int WORDS_PER_ROW  = 40,
    parameter int ROWS           = 480,
    parameter int TRIGGER_COLUMN = 640
) (
    input  logic                                clkDiv,
    input  logic                                rst,
    input  logic [8:0]                          row,
    input  logic [9:0]                          column,
    input  logic [DATA_WIDTH*WORDS_PER_ROW-1:0] writeRow,
    input  logic                                freeze,
    output logic [DATA_WIDTH*WORDS_PER_ROW-1:0] readRow,
    output logic                                reading,
    output logic                                busy,
    output logic                                overrun,
    output logic                                bank,
    row_memory_streamer_if.master               mem
);
    localparam int         ROW_W     = DATA_WIDTH * WORDS_PER_ROW;
    localparam int         IDX_W     = $clog2(ROW_W);
    localparam logic [5:0] LAST_WORD = 6'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, LOAD} state_t;

    state_t           state;
    logic [ROW_W-1:0] wbuf;
    logic [ROW_W-1:0] rbuf;
    logic [8:0]       wRow;
    logic [8:0]       rRow;
    logic [5:0]       word;
    logic             swapPending;

    logic [5:0]       nextWord;
    logic [IDX_W-1:0] wordBase;
    logic [IDX_W-1:0] nextBase;
    logic [9:0]       rowPlus2;
    logic [8:0]       nextRRow;
    logic             trigger;
    logic             swapReq;
    logic             ackd;

    assign nextWord = word + 6'd1;
    assign wordBase = IDX_W'(word) * IDX_W'(DATA_WIDTH);
    assign nextBase = IDX_W'(nextWord) * IDX_W'(DATA_WIDTH);
    // Source row is two ahead of the display row and wraps inside the visible frame.
    assign rowPlus2 = {1'b0, row} + 10'd2;
    assign nextRRow = (rowPlus2 >= 10'(ROWS)) ? 9'(rowPlus2 - 10'(ROWS)) : rowPlus2[8:0];
    assign trigger  = (column == 10'(TRIGGER_COLUMN)) && ({1'b0, row} < 10'(ROWS));
    assign swapReq  = ({1'b0, row} == 10'(ROWS)) && (column == 10'd0) && !freeze;
    assign ackd     = mem.memAck && mem.memReq;

    always_ff @(posedge clkDiv) begin
        if (rst) begin
            state        <= IDLE;
            wbuf         <= '0;
            rbuf         <= '0;
            wRow         <= '0;
            rRow         <= '0;
            word         <= '0;
            swapPending  <= 1'b0;
            readRow      <= '0;
            reading      <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            bank         <= 1'b0;
            mem.memReq   <= 1'b0;
            mem.memWe    <= 1'b0;
            mem.memAddr  <= '0;
            mem.memWData <= '0;
        end else begin
            reading <= 1'b0;
            if (trigger && state != IDLE)
                overrun <= 1'b1;

            // A swap requested mid-transaction lands on the LOAD cycle so one line never spans both banks.
            if ((state == IDLE && swapReq) || (state == LOAD && (swapPending || swapReq))) begin
                bank        <= ~bank;
                swapPending <= 1'b0;
            end else if (swapReq) begin
                swapPending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        wbuf         <= writeRow;
                        wRow         <= row;
                        rRow         <= nextRRow;
                        word         <= '0;
                        busy         <= 1'b1;
                        mem.memReq   <= 1'b1;
                        mem.memWe    <= 1'b1;
                        mem.memAddr  <= {~bank, row, 6'd0};
                        mem.memWData <= writeRow[DATA_WIDTH-1:0];
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    if (ackd) begin
                        if (word == LAST_WORD) begin
                            word        <= '0;
                            mem.memWe   <= 1'b0;
                            mem.memAddr <= {bank, rRow, 6'd0};
                            state       <= READ;
                        end else begin
                            word         <= nextWord;
                            mem.memAddr  <= {~bank, wRow, nextWord};
                            mem.memWData <= wbuf[nextBase +: DATA_WIDTH];
                        end
                    end
                end
                READ: begin
                    if (ackd) begin
                        rbuf[wordBase +: DATA_WIDTH] <= mem.memRData;
                        if (word == LAST_WORD) begin
                            word       <= '0;
                            mem.memReq <= 1'b0;
                            state      <= LOAD;
                        end else begin
                            word        <= nextWord;
                            mem.memAddr <= {bank, rRow, nextWord};
                        end
                    end
                end
                LOAD: begin
                    readRow <= rbuf;
                    reading <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_row_memory_streamer.sv
// tb/tb_row_memory_streamer.sv - scoreboard bench for row_memory_streamer
module tb_row_memory_streamer;
    logic         clkDiv   = 1'b0;
    logic         rst      = 1'b1;
    logic [8:0]   row      = '0;
    logic [9:0]   column   = 10'd100;
    logic [639:0] writeRow = '0;
    logic         freeze   = 1'b0;
    logic [639:0] readRow;
    logic         reading;
    logic         busy;
    logic         overrun;
    logic         bank;

    row_memory_streamer_if mem ();

    row_memory_streamer dut (
        .clkDiv   (clkDiv),
        .rst      (rst),
        .row      (row),
        .column   (column),
        .writeRow (writeRow),
        .freeze   (freeze),
        .readRow  (readRow),
        .reading  (reading),
        .busy     (busy),
        .overrun  (overrun),
        .bank     (bank),
        .mem      (mem)
    );

    always #5 clkDiv = ~clkDiv;

    int           tests = 0;
    int           fails = 0;
    logic         memEnable = 1'b1;
    logic [32:0]  reqQ[$];
    logic [639:0] readQ[$];
    logic [32:0]  expReq;
    logic [639:0] expRead;
    logic [639:0] wr2;
    int           n;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clkDiv);
        #2;
    endtask

    // Memory: acks every other cycle, returns the word index as read data.
    initial begin
        mem.memAck   = 1'b0;
        mem.memRData = '0;
        forever begin
            @(negedge clkDiv);
            if (mem.memAck) begin
                mem.memAck = 1'b0;
            end else if (memEnable && mem.memReq && !rst) begin
                if (reqQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected request: we=%0b addr=%0h", mem.memWe, mem.memAddr);
                end else begin
                    expReq = reqQ.pop_front();
                    if (expReq[32])
                        check("write request", 640'({mem.memWe, mem.memAddr, mem.memWData}), 640'(expReq));
                    else
                        check("read request", 640'({mem.memWe, mem.memAddr}), 640'(expReq[32:16]));
                end
                mem.memRData = {10'd0, mem.memAddr[5:0]};
                mem.memAck   = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clkDiv);
            if (reading) begin
                if (readQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected reading pulse: readRow=%0h", readRow);
                end else begin
                    check("readRow", readRow, readQ.pop_front());
                end
                check("busy with reading", 640'(busy), 640'(0));
            end
        end
    end

    task automatic startLine(input logic [8:0] r, input logic [8:0] rd, input logic [639:0] wr, input logic b);
        writeRow = wr;
        row      = r;
        column   = 10'd640;
        for (int w = 0; w < 40; w++)
            reqQ.push_back({1'b1, ~b, r, 6'(w), 16'(wr >> (16 * w))});
        for (int w = 0; w < 40; w++)
            reqQ.push_back({1'b0, b, rd, 6'(w), 16'h0000});
        readQ.push_back(expRead);
        tick(1);
        column = 10'd100;
        row    = '0;
    endtask

    task automatic endLine(input string name);
        int c = 0;
        while (busy && c < 1000) begin
            tick(1);
            c++;
        end
        tests++;
        if (busy) begin
            fails++;
            $display("FAIL %s: still busy after %0d cycles", name, c);
        end
        tick(1);
        check({name, " reading one cycle"}, 640'(reading), 640'(0));
        check({name, " requests consumed"}, 640'(reqQ.size()), 640'(0));
        check({name, " reads consumed"}, 640'(readQ.size()), 640'(0));
    endtask

    task automatic swapPulse();
        row    = 9'd480;
        column = 10'd0;
        tick(1);
        row    = '0;
        column = 10'd100;
    endtask

    initial begin
        expRead = '0;
        wr2     = '0;
        for (int w = 0; w < 40; w++) begin
            expRead = expRead | (640'(w) << (16 * w));
            wr2     = wr2 | (640'(16'hC000 | 16'(w * 257)) << (16 * w));
        end

        tick(3);
        check("reset readRow", readRow, 640'(0));
        check("reset reading", 640'(reading), 640'(0));
        check("reset busy", 640'(busy), 640'(0));
        check("reset overrun", 640'(overrun), 640'(0));
        check("reset bank", 640'(bank), 640'(0));
        check("reset memReq", 640'(mem.memReq), 640'(0));
        check("reset memWe", 640'(mem.memWe), 640'(0));
        check("reset memAddr", 640'(mem.memAddr), 640'(0));
        check("reset memWData", 640'(mem.memWData), 640'(0));
        rst = 1'b0;
        tick(2);

        startLine(9'd5, 9'd7, 640'h1, 1'b0);
        endLine("row5");
        startLine(9'd100, 9'd102, wr2, 1'b0);
        endLine("row100");
        startLine(9'd479, 9'd1, wr2, 1'b0);
        endLine("row479");
        startLine(9'd478, 9'd0, ~wr2, 1'b0);
        endLine("row478");

        swapPulse();
        check("bank after swap", 640'(bank), 640'(1));
        startLine(9'd10, 9'd12, 640'h1 << 639, 1'b1);
        endLine("row10 bank1");

        freeze = 1'b1;
        swapPulse();
        freeze = 1'b0;
        check("bank frozen", 640'(bank), 640'(1));

        startLine(9'd20, 9'd22, wr2, 1'b1);
        tick(10);
        swapPulse();
        check("bank deferred while busy", 640'(bank), 640'(1));
        endLine("row20 deferred swap");
        check("bank after deferred swap", 640'(bank), 640'(0));

        memEnable = 1'b0;
        startLine(9'd30, 9'd32, wr2, 1'b0);
        tick(200);
        row    = 9'd31;
        column = 10'd640;
        tick(1);
        column = 10'd100;
        row    = '0;
        check("overrun set", 640'(overrun), 640'(1));
        check("overrun busy", 640'(busy), 640'(1));
        check("overrun memReq", 640'(mem.memReq), 640'(1));
        check("overrun memAddr", 640'(mem.memAddr), 640'({1'b1, 9'd30, 6'd0}));
        memEnable = 1'b1;
        endLine("row30 overrun");
        check("overrun sticky", 640'(overrun), 640'(1));

        startLine(9'd40, 9'd42, wr2, 1'b0);
        n = 0;
        while (!(mem.memReq && !mem.memWe && mem.memAddr[5:0] == 6'd20) && n < 1000) begin
            tick(1);
            n++;
        end
        check("reached read word 20", 640'(mem.memAddr), 640'({1'b0, 9'd42, 6'd20}));
        rst       = 1'b1;
        memEnable = 1'b0;
        tick(1);
        check("rst memReq", 640'(mem.memReq), 640'(0));
        check("rst busy", 640'(busy), 640'(0));
        check("rst readRow", readRow, 640'(0));
        check("rst overrun", 640'(overrun), 640'(0));
        check("rst memAddr", 640'(mem.memAddr), 640'(0));
        reqQ.delete();
        readQ.delete();
        rst       = 1'b0;
        memEnable = 1'b1;
        tick(2);
        startLine(9'd50, 9'd52, wr2, 1'b0);
        endLine("row50 after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/row_memory_streamer.md
Name: row_memory_streamer

Overview:
- Memory-side partner of the Life row calculator.
- Once per display line, during horizontal blanking:
  - writes the just-computed next-generation row (writeRow) back to the row store;
  - fetches the next source row into a 640-bit holding register;
  - presents that register as readRow and signals it with a single-cycle `reading` pulse.
- The row store is double-banked, so reads come from the current generation and writes go to the next. Banks swap once per frame.

Parameters:
- DATA_WIDTH, 16, memory word width in bits.
- WORDS_PER_ROW, 40, words per row; row width = DATA_WIDTH*WORDS_PER_ROW = 640.
- ROWS, 480, visible rows per generation.
- TRIGGER_COLUMN, 640, column at which a line transaction starts.

Ports:
- clkDiv  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- row  in  9  current display row from the VGA timing block.
- column  in  10  current display column.
- writeRow  in  640  next-generation row from the calculator.
- freeze  in  1  when high, the bank swap at frame end is suppressed.
- readRow  out  640  fetched row; stable except while being loaded.
- reading  out  1  one-cycle pulse: readRow updated.
- busy  out  1  a line transaction is in progress.
- overrun  out  1  sticky; a trigger arrived while busy.
- bank  out  1  current read bank; the write bank is ~bank.
- memReq  out  1  memory request.
- memWe  out  1  1 = write, 0 = read; valid while memReq is high.
- memAddr  out  16  {bank bit, row index[8:0], word index[5:0]}.
- memWData  out  16  write data.
- memRData  in  16  read data; valid in the memAck cycle.
- memAck  in  1  one-cycle acknowledge, completes the current request.

Behaviour:
- Reset values: readRow=0, reading=0, busy=0, overrun=0, bank=0, memReq=0, memWe=0, memAddr=0, memWData=0. State = IDLE.
- Trigger condition: column==TRIGGER_COLUMN and row<ROWS, sampled each cycle.
- IDLE, on trigger:
  - latch writeRow into a 640-bit write buffer;
  - latch wRow=row and rRow=(row+2) mod ROWS;
  - set busy=1, word=0, go to WRITE.
- WRITE:
  - drive memReq=1, memWe=1, memAddr={~bank,wRow,word}, memWData=wbuf[16*word+15:16*word];
  - hold all of these unchanged until memAck;
  - on memAck: word++; if word was 39, set word=0 and go to READ.
- READ:
  - drive memReq=1, memWe=0, memAddr={bank,rRow,word};
  - on memAck: store memRData into rbuf slice `word`; word++; if word was 39, go to LOAD.
- LOAD:
  - readRow<=rbuf, reading<=1 for exactly this one cycle;
  - busy<=0, go to IDLE. readRow then holds until the next LOAD.
- memReq deasserts in the cycle after the final acknowledge of READ; WRITE moves straight into READ with no idle cycle.
- Trigger while busy: the transaction is ignored and overrun<=1. overrun is cleared only by rst.
- memAck while memReq=0: ignored.
- Bank swap: at row==ROWS and column==0, if freeze==0, bank<=~bank.
  - If busy at that moment, the swap is deferred until the cycle the transaction returns to IDLE.
- Wrap-around:
  - row 478 reads row 0; row 479 reads row 1.
  - Word indices 40..63 are never issued.
- Throughput: 80 accesses per line. With a 160-cycle blank, memory must acknowledge within 2 cycles per access on average; otherwise overrun occurs on the next line.
- rst mid-transaction:
  - all outputs return to reset values on the next edge;
  - the in-flight request is abandoned;
  - rbuf contents are discarded.

Test Plan:
- Write-back:
  - Stimulus: reset, writeRow=640'h1 (bit0 set), row=5, column=640, memory acks in the cycle after each request.
  - Required: first request memWe=1, memAddr={1'b1,9'd5,6'd0}, memWData=16'h0001; words 1..39 carry 0.
- Read-back:
  - Stimulus: memory returns word index w as data.
  - Required: 40 reads at {0,9'd7,w}; readRow[16w+15:16w]==w; reading high exactly 1 cycle; busy falls the same cycle.
- Wrap-around:
  - Stimulus: trigger at row=479.
  - Required: reads address row index 1; writes row index 479.
- Overrun:
  - Stimulus: memAck held off 200 cycles, second trigger on the next line.
  - Required: overrun=1; only one reading pulse; no address disturbance.
- Bank swap:
  - Stimulus: row=480, column=0, freeze=0 → bank toggles to 1, and the following line writes bank 0.
  - Stimulus: same with freeze=1 → bank unchanged.
  - Stimulus: swap while busy → toggle occurs on return to IDLE.
- Reset mid-READ:
  - Stimulus: assert rst at word 20.
  - Required: next cycle memReq=0, busy=0, readRow=0; next trigger restarts at word 0 of WRITE.
